// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Takes the stage-three control bundle, selects the
//   write-back data and applies it to architectural state: the 8-entry
//   register file, the stack pointer register (SPR), the PC redirect request
//   and the retired-instruction counter. After a PC load it discards the two
//   younger bundles that are already in flight.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   valid_IN            bundle on *_IN is a real instruction
//   writeAd_IN, write_IN             register file write address / enable
//   PC_load_IN                       instruction redirects the PC
//   SPR_w_IN, SPR_i_IN, SPR_d_IN     SPR load / increment / decrement
//   ADR_MUX_IN                       0 = result_IN, 1 = mem_data_IN
//   result_IN, mem_data_IN           write-back data sources
//   readA_ad, readB_ad               asynchronous read addresses
//   readA_OUT, readB_OUT             read data, bypassed from the committing write
//   SP_OUT                           registered SPR value
//   PC_load_OUT, PC_target_OUT       one-cycle redirect pulse and its target
//   squash_OUT                       high while flushed bundles are discarded
//   retire_cnt_OUT                   committed instruction count (wraps)
module writeback_stage #(
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  SP_RESET = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_IN,
  input  logic [2:0]        writeAd_IN,
  input  logic              write_IN,
  input  logic              PC_load_IN,
  input  logic              SPR_w_IN,
  input  logic              SPR_i_IN,
  input  logic              SPR_d_IN,
  input  logic              ADR_MUX_IN,
  input  logic [DATA_W-1:0] result_IN,
  input  logic [DATA_W-1:0] mem_data_IN,
  input  logic [2:0]        readA_ad,
  input  logic [2:0]        readB_ad,
  output logic [DATA_W-1:0] readA_OUT,
  output logic [DATA_W-1:0] readB_OUT,
  output logic [DATA_W-1:0] SP_OUT,
  output logic              PC_load_OUT,
  output logic [DATA_W-1:0] PC_target_OUT,
  output logic              squash_OUT,
  output logic [15:0]       retire_cnt_OUT
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] rf_p1 [8];
  logic [DATA_W-1:0] sp_p1;
  logic              pc_load_p1;
  logic [DATA_W-1:0] pc_target_p1;
  logic [15:0]       retire_cnt_p1;

  logic [DATA_W-1:0] wb_data_p0;
  logic              commit_p0;
  logic              rf_we_p0;

  // SPR update rule; wraps modulo 2^DATA_W, and simultaneous inc+dec cancel.
  function automatic logic [DATA_W-1:0] sp_next(
    input logic [DATA_W-1:0] sp,
    input logic              w,
    input logic              inc,
    input logic              dec,
    input logic [DATA_W-1:0] wd
  );
    if (w)
      return wd;
    else if (inc && !dec)
      return sp + DATA_W'(1);
    else if (dec && !inc)
      return sp - DATA_W'(1);
    else
      return sp;
  endfunction

  // ---- stage p0: bundle decode, commit qualification, read bypass ----
  assign wb_data_p0 = ADR_MUX_IN ? mem_data_IN : result_IN;
  assign commit_p0  = valid_IN && (state_q == RUN);
  assign rf_we_p0   = commit_p0 && write_IN;

  assign readA_OUT = (rf_we_p0 && (readA_ad == writeAd_IN)) ? wb_data_p0 : rf_p1[readA_ad];
  assign readB_OUT = (rf_we_p0 && (readB_ad == writeAd_IN)) ? wb_data_p0 : rf_p1[readB_ad];

  // Flush sequencing: a committed redirect spends two cycles discarding
  // the bundles fetched down the wrong path.
  always_comb begin
    state_d    = state_q;
    squash_OUT = 1'b0;
    case (state_q)
      RUN:     if (commit_p0 && PC_load_IN) state_d = FLUSH1;
      FLUSH1: begin
        squash_OUT = 1'b1;
        state_d    = FLUSH2;
      end
      FLUSH2: begin
        squash_OUT = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // ---- stage p1: architectural state ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RUN;
      sp_p1         <= SP_RESET;
      pc_load_p1    <= 1'b0;
      pc_target_p1  <= '0;
      retire_cnt_p1 <= '0;
      for (int i = 0; i < 8; i++) rf_p1[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_load_p1 <= 1'b0;
      if (commit_p0) begin
        if (write_IN) rf_p1[writeAd_IN] <= wb_data_p0;
        sp_p1         <= sp_next(sp_p1, SPR_w_IN, SPR_i_IN, SPR_d_IN, wb_data_p0);
        retire_cnt_p1 <= retire_cnt_p1 + 16'd1;
        if (PC_load_IN) begin
          pc_load_p1   <= 1'b1;
          pc_target_p1 <= wb_data_p0;
        end
      end
    end
  end

  assign SP_OUT         = sp_p1;
  assign PC_load_OUT    = pc_load_p1;
  assign PC_target_OUT  = pc_target_p1;
  assign retire_cnt_OUT = retire_cnt_p1;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        CLK, RST;
  logic        valid_IN, write_IN, PC_load_IN, SPR_w_IN, SPR_i_IN, SPR_d_IN, ADR_MUX_IN;
  logic [2:0]  writeAd_IN, readA_ad, readB_ad;
  logic [15:0] result_IN, mem_data_IN;
  logic [15:0] readA_OUT, readB_OUT, SP_OUT, PC_target_OUT, retire_cnt_OUT;
  logic        PC_load_OUT, squash_OUT;

  writeback_stage #(.DATA_W(16), .SP_RESET(16'hFFFF)) dut (
    .CLK(CLK), .RST(RST), .valid_IN(valid_IN), .writeAd_IN(writeAd_IN),
    .write_IN(write_IN), .PC_load_IN(PC_load_IN), .SPR_w_IN(SPR_w_IN),
    .SPR_i_IN(SPR_i_IN), .SPR_d_IN(SPR_d_IN), .ADR_MUX_IN(ADR_MUX_IN),
    .result_IN(result_IN), .mem_data_IN(mem_data_IN),
    .readA_ad(readA_ad), .readB_ad(readB_ad),
    .readA_OUT(readA_OUT), .readB_OUT(readB_OUT), .SP_OUT(SP_OUT),
    .PC_load_OUT(PC_load_OUT), .PC_target_OUT(PC_target_OUT),
    .squash_OUT(squash_OUT), .retire_cnt_OUT(retire_cnt_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: architectural state plus a count of flush cycles left.
  logic [15:0] m_rf [8];
  logic [15:0] m_sp, m_tgt, m_cnt;
  logic        m_pcl;
  int          m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_sp = 16'hFFFF; m_tgt = 16'h0000; m_cnt = 16'h0000; m_pcl = 1'b0; m_flush = 0;
  endtask

  function automatic logic [15:0] m_wb();
    return ADR_MUX_IN ? mem_data_IN : result_IN;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] ad);
    if (valid_IN && m_flush == 0 && write_IN && ad == writeAd_IN) return m_wb();
    return m_rf[ad];
  endfunction

  task automatic set_in(input logic v, input logic [2:0] ad, input logic w, input logic pcl,
                        input logic sw, input logic si, input logic sd, input logic mux,
                        input logic [15:0] res, input logic [15:0] mem);
    valid_IN = v; writeAd_IN = ad; write_IN = w; PC_load_IN = pcl;
    SPR_w_IN = sw; SPR_i_IN = si; SPR_d_IN = sd; ADR_MUX_IN = mux;
    result_IN = res; mem_data_IN = mem;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    bit commit;
    logic [15:0] wb;
    #1;
    check("readA", readA_OUT, m_read(readA_ad));
    check("readB", readB_OUT, m_read(readB_ad));
    @(posedge CLK);
    if (RST) m_reset();
    else begin
      commit = valid_IN && (m_flush == 0);
      wb     = m_wb();
      if (m_flush > 0) m_flush--;
      m_pcl = 1'b0;
      if (commit) begin
        if (write_IN) m_rf[writeAd_IN] = wb;
        if (SPR_w_IN) m_sp = wb;
        else if (SPR_i_IN && !SPR_d_IN) m_sp = m_sp + 16'd1;
        else if (SPR_d_IN && !SPR_i_IN) m_sp = m_sp - 16'd1;
        m_cnt = m_cnt + 16'd1;
        if (PC_load_IN) begin
          m_pcl = 1'b1; m_tgt = wb; m_flush = 2;
        end
      end
    end
    #1;
    check("SP", SP_OUT, m_sp);
    check("PC_load", PC_load_OUT, m_pcl);
    check("PC_target", PC_target_OUT, m_tgt);
    check("squash", squash_OUT, m_flush != 0);
    check("retire_cnt", retire_cnt_OUT, m_cnt);
    @(negedge CLK);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] cnt0;
    RST = 1'b1; readA_ad = 0; readB_ad = 0;
    idle();
    @(negedge CLK); @(negedge CLK);
    m_reset();
    step();
    check("rst_sp", SP_OUT, 16'hFFFF);
    check("rst_cnt", retire_cnt_OUT, 16'h0);
    check("rst_pcl", PC_load_OUT, 1'b0);
    RST = 1'b0;

    // Write r5 from result, observe bypass then stored value
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 16'h1234, 16'h0);
    readA_ad = 5; readB_ad = 4;
    #1 check("t1_bypass", readA_OUT, 16'h1234);
    step();
    idle();
    #1 check("t1_rf", readA_OUT, 16'h1234);
    check("t1_cnt", retire_cnt_OUT, 16'd1);
    step();

    // Write r2 from memory data
    set_in(1, 2, 1, 0, 0, 0, 0, 1, 16'h1111, 16'hBEEF);
    readB_ad = 2;
    step();
    idle();
    #1 check("t2_rf", readB_OUT, 16'hBEEF);
    step();

    // SPR wrap, dec, hold, load priority
    RST = 1'b1; step(); RST = 1'b0;
    set_in(1, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0); step(); check("t3_inc", SP_OUT, 16'h0000);
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0); step(); check("t3_dec", SP_OUT, 16'hFFFF);
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0); step(); check("t3_hold", SP_OUT, 16'hFFFF);
    set_in(1, 0, 0, 0, 1, 1, 0, 0, 16'h0100, 16'h0); step(); check("t3_load", SP_OUT, 16'h0100);

    // Redirect with link write, then two squashed writes to r1
    cnt0 = retire_cnt_OUT;
    set_in(1, 7, 1, 1, 0, 0, 0, 0, 16'h0040, 16'h0);
    readA_ad = 7; readB_ad = 1;
    step();
    check("t4_pcl", PC_load_OUT, 1'b1);
    check("t4_tgt", PC_target_OUT, 16'h0040);
    check("t4_sq1", squash_OUT, 1'b1);
    set_in(1, 1, 1, 1, 0, 1, 0, 0, 16'h5555, 16'h0);
    step();
    check("t4_pcl_pulse", PC_load_OUT, 1'b0);
    check("t4_sq2", squash_OUT, 1'b1);
    step();
    check("t4_sq_end", squash_OUT, 1'b0);
    check("t4_tgt_hold", PC_target_OUT, 16'h0040);
    idle();
    #1 check("t4_r1_dropped", readB_OUT, 16'h0000);
    check("t4_r7", readA_OUT, 16'h0040);
    check("t4_cnt", retire_cnt_OUT, cnt0 + 16'd1);
    step();

    // Reset during FLUSH1
    set_in(1, 7, 1, 1, 0, 0, 0, 0, 16'h0080, 16'h0);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5_sq", squash_OUT, 1'b0);
    check("t5_sp", SP_OUT, 16'hFFFF);
    idle(); readA_ad = 7;
    #1 check("t5_r7", readA_OUT, 16'h0000);
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 16'hA5A5, 16'h0); readB_ad = 3;
    step();
    idle();
    #1 check("t5_r3", readB_OUT, 16'hA5A5);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom));
      readA_ad = 3'($urandom); readB_ad = 3'($urandom);
      if ($urandom_range(0, 3) == 0) readA_ad = writeAd_IN;
      step();
    end
    RST = 1'b0;

    // Counter wrap after 65536 commits
    RST = 1'b1; idle(); step(); RST = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    for (int n = 0; n < 65536; n++) step();
    check("t6_wrap", retire_cnt_OUT, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
